pipe_elastic_stage: RTL

PIPE_ELASTIC_STAGE -- requirements
Module: pipe_elastic_stage

---
 rtl/mips_core_pkg.sv | 21 ++
 rtl/pipe_elastic_mem.sv | 33 +++
 rtl/pipe_elastic_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared constants and types for the elastic pipeline stage.
package mips_core_pkg;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 256;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 8;

  // Occupancy status of a buffered stage
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_status_e;

  // Pointer width; a single-entry buffer still gets a 1-bit pointer
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_elastic_mem.sv
// Storage array for the elastic stage: one write port, async read, sync clear.
module pipe_elastic_mem
  import mips_core_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          i_clear,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Clear has priority over write
  always_ff @(posedge clk) begin
    if (i_clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: in-order circular buffer with registered handshakes.
module pipe_elastic_stage
  import mips_core_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned DEPTH          = 2,
  parameter int unsigned CLEAR_ON_FLUSH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned AW = addr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("pipe_elastic_stage: WIDTH %0d out of range", WIDTH);
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("pipe_elastic_stage: DEPTH %0d out of range", DEPTH);
  end
  if (CLEAR_ON_FLUSH > 1) begin : g_bad_clear
    $error("pipe_elastic_stage: CLEAR_ON_FLUSH must be 0 or 1");
  end

  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  occ_status_e      w_status;
  logic             w_push;
  logic             w_pop;
  logic             w_mem_clear;
  logic             w_mem_we;
  logic [WIDTH-1:0] w_rdata;

  // Status derived from registered occupancy only
  always_comb begin
    w_status = OCC_PARTIAL;
    if (r_count == '0) begin
      w_status = OCC_EMPTY;
    end else if (r_count == CW'(DEPTH)) begin
      w_status = OCC_FULL;
    end
  end

  assign o_ready = (w_status != OCC_FULL);
  assign o_valid = (w_status != OCC_EMPTY);
  assign o_count = r_count;
  assign o_data  = o_valid ? w_rdata : '0;

  assign w_push = i_valid && o_ready;
  assign w_pop  = o_valid && i_ready;

  // Reset overrides flush, flush overrides the datapath write
  assign w_mem_clear = rst || (i_flush && (CLEAR_ON_FLUSH != 0));
  assign w_mem_we    = w_push && !rst && !i_flush;

  // Pointer and occupancy update; explicit wrap handles non-power-of-two depths
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  pipe_elastic_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_clear (w_mem_clear),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

endmodule
